// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: control word, FSM states, funct3 size codes.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [3:0] byte_en_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [2:0] funct3;
  } control_type;

  // A faulted instruction still retires but must not write the register file.
  function automatic control_type squash_write(input control_type c);
    control_type r;
    r = c;
    r.reg_write = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// req rises with we/addr/be/wdata stable and holds them until a cycle with gnt=1, which is the
// transfer cycle; for loads, rvalid pulses once with rdata no earlier than the cycle after gnt.
interface mem_access_stage_if #(
  parameter int ADDR_WIDTH = 32
) ();
  import mem_access_stage_pkg::*;

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-3:0] addr;
  byte_en_t              be;
  logic [31:0]           wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_access_stage_lsu_align.sv
// Combinational lane logic: store byte enables / replication, misalignment, load extraction.
module lsu_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output byte_en_t    be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [31:0] lane;
  logic        is_unsigned;

  // Move the addressed byte/half down to bit 0 before extension.
  assign lane        = rdata >> {addr_lo, 3'b000};
  assign is_unsigned = funct3[2];

  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    misaligned = 1'b0;
    load_data  = rdata;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{lane[7] & ~is_unsigned}}, lane[7:0]};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
        load_data  = {{16{lane[15] & ~is_unsigned}}, lane[15:0]};
      end
      // Word and every unrecognised funct3 behave as a full-word access.
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory bus, stalls upstream while busy,
// and registers the MEM/WB slot (including misaligned / bus-timeout faults).
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  control_type        control_in,
  input  logic [31:0]        alu_data,
  input  logic [31:0]        memory_data,
  output logic               stall,
  output logic [31:0]        mem_forward_data,
  mem_access_stage_if.master dmem,
  output logic               wb_valid,
  output control_type        control_out,
  output logic [31:0]        wb_alu_data,
  output logic [31:0]        wb_load_data,
  output logic               misaligned,
  output logic               bus_error,
  output mem_state_t         dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t    state;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_next;
  logic          access;
  logic          expire;
  byte_en_t      al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   al_load;
  logic          al_mis;

  lsu_align u_align (
    .funct3     (control_in.funct3),
    .addr_lo    (alu_data[1:0]),
    .store_data (memory_data),
    .rdata      (dmem.rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .misaligned (al_mis),
    .load_data  (al_load)
  );

  assign access           = valid_in & (control_in.mem_read | control_in.mem_write);
  assign mem_forward_data = alu_data;
  assign dbg_state        = state;

  // expire marks the last allowed REQ/WAIT cycle; a gnt/rvalid in that same cycle still wins.
  assign expire   = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign tmo_next = (tmo_cnt == CW'(TIMEOUT_CYCLES)) ? tmo_cnt : tmo_cnt + 1'b1;

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = access & ~al_mis;
      REQ:     stall = dmem.gnt ? ~dmem.we : ~expire;
      WAIT:    stall = dmem.rvalid ? 1'b0 : ~expire;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      dmem.req     <= 1'b0;
      dmem.we      <= 1'b0;
      dmem.addr    <= '0;
      dmem.be      <= '0;
      dmem.wdata   <= '0;
      wb_valid     <= 1'b0;
      control_out  <= '0;
      wb_alu_data  <= '0;
      wb_load_data <= '0;
      misaligned   <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (access && !al_mis) begin
              state      <= REQ;
              tmo_cnt    <= '0;
              dmem.req   <= 1'b1;
              dmem.we    <= control_in.mem_write;
              dmem.addr  <= alu_data[ADDR_WIDTH-1:2];
              dmem.be    <= al_be;
              dmem.wdata <= control_in.mem_write ? al_wdata : '0;
            end else begin
              // Non-memory op, or a misaligned access retired without a bus cycle.
              wb_valid     <= 1'b1;
              misaligned   <= access;
              control_out  <= access ? squash_write(control_in) : control_in;
              wb_alu_data  <= alu_data;
              wb_load_data <= '0;
            end
          end
        end
        REQ: begin
          if (dmem.gnt) begin
            dmem.req <= 1'b0;
            if (dmem.we) begin
              state        <= IDLE;
              wb_valid     <= 1'b1;
              control_out  <= control_in;
              wb_alu_data  <= alu_data;
              wb_load_data <= '0;
            end else begin
              state   <= WAIT;
              tmo_cnt <= tmo_next;
            end
          end else if (expire) begin
            state        <= IDLE;
            dmem.req     <= 1'b0;
            wb_valid     <= 1'b1;
            bus_error    <= 1'b1;
            control_out  <= squash_write(control_in);
            wb_alu_data  <= alu_data;
            wb_load_data <= '0;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        WAIT: begin
          if (dmem.rvalid) begin
            state        <= IDLE;
            wb_valid     <= 1'b1;
            control_out  <= control_in;
            wb_alu_data  <= alu_data;
            wb_load_data <= al_load;
          end else if (expire) begin
            state        <= IDLE;
            wb_valid     <= 1'b1;
            bus_error    <= 1'b1;
            control_out  <= squash_write(control_in);
            wb_alu_data  <= alu_data;
            wb_load_data <= '0;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: bench-side memory responder, result model and WB scoreboard.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in;
  control_type control_in;
  logic [31:0] alu_data;
  logic [31:0] memory_data;
  logic        stall;
  logic [31:0] mem_forward_data;
  logic        wb_valid;
  control_type control_out;
  logic [31:0] wb_alu_data;
  logic [31:0] wb_load_data;
  logic        misaligned;
  logic        bus_error;
  mem_state_t  dbg_state;

  int total = 0;
  int bad = 0;
  logic [71:0] exp_q[$];
  logic [29:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;

  mem_access_stage_if #(.ADDR_WIDTH(32)) dmem ();

  mem_access_stage #(.TIMEOUT_CYCLES(T), .ADDR_WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_in         (valid_in),
    .control_in       (control_in),
    .alu_data         (alu_data),
    .memory_data      (memory_data),
    .stall            (stall),
    .mem_forward_data (mem_forward_data),
    .dmem             (dmem),
    .wb_valid         (wb_valid),
    .control_out      (control_out),
    .wb_alu_data      (wb_alu_data),
    .wb_load_data     (wb_load_data),
    .misaligned       (misaligned),
    .bus_error        (bus_error),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic control_type mk(input logic rd, input logic wr, input logic rw, input logic [2:0] f3);
    control_type c;
    c.mem_read = rd;
    c.mem_write = wr;
    c.reg_write = rw;
    c.funct3 = f3;
    return c;
  endfunction

  function automatic int model_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    case (model_size(f3))
      1:       return 4'(1 << off);
      2:       return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] d);
    case (model_size(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int unsigned off;
    off = a % 4;
    case (f3)
      3'b000: begin v = (rd >> (8 * off)) & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'b100:       v = (rd >> (8 * off)) & 32'hFF;
      3'b001: begin v = (rd >> (8 * off)) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'b101:       v = (rd >> (8 * off)) & 32'hFFFF;
      default:      v = rd;
    endcase
    return v;
  endfunction

  // ---------------- driver + memory responder ----------------
  // Presents one instruction at a negedge, answers the bus after gnt_lat REQ cycles and
  // rv_lat further WAIT cycles, and returns at the negedge after the instruction retires.
  task automatic issue(input control_type c, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input int gnt_lat, input int rv_lat, output int stalls);
    bit acc, mis, tmo, is_ld, waiting, done;
    int rq, wt, exp_stall;
    logic [31:0] ld;
    acc   = c.mem_read | c.mem_write;
    is_ld = c.mem_read & ~c.mem_write;
    mis   = acc && ((a % model_size(c.funct3)) != 0);
    tmo   = 1'b0;
    if (!acc || mis) exp_stall = 0;
    else if (!is_ld) begin tmo = (gnt_lat >= T); exp_stall = tmo ? T : 1 + gnt_lat; end
    else begin tmo = (gnt_lat + 1 + rv_lat >= T); exp_stall = tmo ? T : 2 + gnt_lat + rv_lat; end
    ld = (acc && is_ld && !mis && !tmo) ? model_load(c.funct3, a, rd) : 32'h0;
    exp_q.push_back({c.reg_write & ~(mis | tmo), c.mem_read, c.mem_write, c.funct3, a, ld, mis, tmo});

    cap_addr = '0; cap_be = '0; cap_wdata = '0;
    valid_in = 1'b1; control_in = c; alu_data = a; memory_data = d;
    rq = 0; wt = 0; waiting = 0; done = 0; stalls = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
      if (dmem.req) begin
        if (rq == gnt_lat) begin
          dmem.gnt = 1'b1;
          cap_addr = dmem.addr; cap_be = dmem.be; cap_wdata = dmem.wdata;
          if (c.mem_write)
            check("bus_store", {dmem.we, dmem.addr, dmem.be, dmem.wdata},
                  {1'b1, a[31:2], model_be(c.funct3, a), model_wd(c.funct3, d)});
          else
            check("bus_load", {dmem.we, dmem.addr}, {1'b0, a[31:2]});
          waiting = is_ld;
        end
        rq++;
      end else if (waiting) begin
        if (wt == rv_lat) begin
          dmem.rvalid = 1'b1; dmem.rdata = rd; waiting = 0;
        end
        wt++;
      end
      #1;
      if (stall) stalls++;
      else done = 1;
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    if (!done) check("retire_bound", 0, 1);
    else begin
      #1;
      check("wb_latency", wb_valid, 1'b1);
      check("req_idle_after", dmem.req, 1'b0);
      check("stall_cycles", stalls, exp_stall);
    end
    valid_in = 1'b0; dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  initial begin
    logic [71:0] e;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (wb_valid) begin
        if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wb_result", {control_out.reg_write, control_out.mem_read, control_out.mem_write,
                              control_out.funct3, wb_alu_data, wb_load_data, misaligned, bus_error}, e);
        end
      end else begin
        check("flags_quiet", {misaligned, bus_error}, 2'b00);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int st;
    bit got;
    valid_in = 1'b0; control_in = '0; alu_data = '0; memory_data = '0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    #1;
    check("rst_bus", {dmem.req, dmem.we, dmem.addr, dmem.be, dmem.wdata}, 0);
    check("rst_wb", {stall, wb_valid, control_out, wb_alu_data, wb_load_data, misaligned, bus_error}, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: SW, immediate grant
    issue(mk(0, 1, 0, F3_W), 32'h104, 32'hDEAD_BEEF, 0, 0, 0, st);
    check("t1_bus", {cap_addr, cap_be, cap_wdata}, {30'h41, 4'b1111, 32'hDEAD_BEEF});
    check("t1_stall", st, 1);

    // 2: sub-word loads with sign/zero extension
    issue(mk(1, 0, 1, F3_B), 32'h203, 0, 32'h80FF_FF7F, 0, 0, st);
    check("t2_lb", wb_load_data, 32'hFFFF_FF80);
    issue(mk(1, 0, 1, F3_BU), 32'h203, 0, 32'h80FF_FF7F, 0, 0, st);
    check("t2_lbu", wb_load_data, 32'h0000_0080);
    issue(mk(1, 0, 1, F3_H), 32'h202, 0, 32'h80FF_FF7F, 1, 0, st);
    check("t2_lh", wb_load_data, 32'hFFFF_80FF);
    issue(mk(1, 0, 1, F3_HU), 32'h202, 0, 32'h80FF_FF7F, 0, 1, st);
    issue(mk(1, 0, 1, F3_B), 32'h200, 0, 32'h80FF_FF7F, 0, 0, st);
    issue(mk(1, 0, 1, 3'b111), 32'h208, 0, 32'h1357_9BDF, 0, 0, st);

    // 3: sub-word stores
    issue(mk(0, 1, 0, F3_B), 32'h12, 32'h0000_00A5, 0, 0, 0, st);
    check("t3_sb", {cap_be, cap_wdata}, {4'b0100, 32'hA5A5_A5A5});
    issue(mk(0, 1, 0, F3_H), 32'h12, 32'h0000_1234, 0, 2, 0, st);
    check("t3_sh", {cap_be, cap_wdata}, {4'b1100, 32'h1234_1234});

    // 4: misaligned accesses never reach the bus
    issue(mk(1, 0, 1, F3_W), 32'h101, 0, 0, 0, 0, st);
    check("t4_flags", {misaligned, control_out.reg_write, wb_valid}, 3'b101);
    check("t4_stall", st, 0);
    issue(mk(0, 1, 0, F3_H), 32'h13, 32'h55, 0, 0, 0, st);
    issue(mk(1, 0, 1, F3_HU), 32'h201, 0, 0, 0, 0, st);

    // 5: timeouts, expiry-cycle wins, then a plain ALU op
    issue(mk(0, 1, 0, F3_W), 32'h400, 32'h1111_2222, 0, 99, 0, st);
    check("t5_berr", {bus_error, wb_valid, control_out.reg_write}, 3'b110);
    issue(mk(0, 0, 1, F3_B), 32'h0000_0055, 0, 0, 0, 0, st);
    check("t5_add", {wb_valid, control_out.reg_write, wb_alu_data, bus_error}, {2'b11, 32'h55, 1'b0});
    issue(mk(1, 0, 1, F3_W), 32'h404, 0, 32'hAAAA_5555, 1, 5, st);
    issue(mk(0, 1, 0, F3_W), 32'h408, 32'h0BAD_F00D, 0, 3, 0, st);
    issue(mk(1, 0, 1, F3_W), 32'h40C, 0, 32'h7654_3210, 0, 2, st);
    check("t5_edge_ld", {bus_error, wb_load_data}, {1'b0, 32'h7654_3210});

    // 6: reset while waiting for rvalid, then a late rvalid
    valid_in = 1'b1; control_in = mk(1, 0, 1, F3_W); alu_data = 32'h300; memory_data = '0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      dmem.gnt = dmem.req;
      @(posedge clk); #1;
      if (dbg_state == WAIT) got = 1;
      @(negedge clk);
    end
    check("t6_reach_wait", got, 1);
    dmem.gnt = 1'b0;
    #2 reset = 1'b1; valid_in = 1'b0;
    #1;
    check("t6_rst_bus", {dmem.req, dmem.we, dmem.addr, dmem.be, dmem.wdata}, 0);
    check("t6_rst_wb", {stall, wb_valid, control_out, wb_alu_data, wb_load_data, misaligned, bus_error}, 0);
    check("t6_rst_state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("t6_rvalid_ignored", {wb_valid, dbg_state}, {1'b0, IDLE});
    @(negedge clk);
    dmem.rvalid = 1'b0; dmem.rdata = '0;
    @(negedge clk);

    // back-to-back loads, 2-cycle rvalid latency
    issue(mk(1, 0, 1, F3_W), 32'h500, 0, 32'h0000_0001, 0, 1, st);
    issue(mk(1, 0, 1, F3_W), 32'h504, 0, 32'h0000_0002, 0, 1, st);
    check("t6_second_ld", {wb_alu_data, wb_load_data}, {32'h504, 32'h2});

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
